counter_up_down_mod: RTL and testbench

//  Parametrised up/down counter with a run-time limit (count range 0..limit),
//  a programmable step, and a selectable wrap or saturate mode at the bounds.

---
 rtl/counter_up_down_mod_if.sv | 47 ++++
 rtl/counter_up_down_mod.sv | 101 ++++++++++
 tb/tb_counter_up_down_mod.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_up_down_mod_if.sv
// ============================================================================
// Module      : counter_up_down_mod_if
// Description : Control/status bundle for counter_up_down_mod (CNT_STICKY_EN
//               adds the sticky wrap flag and its clear).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface counter_up_down_mod_if #(
    parameter int BITS      = 8,
    parameter int STEP_BITS = 4
);
    logic                 enable;
    logic                 up;
    logic                 load;
    logic [BITS-1:0]      load_val;
    logic [BITS-1:0]      limit;
    logic [STEP_BITS-1:0] step;
    logic                 sat_mode;
    logic [BITS-1:0]      q;
    logic                 tc;
    logic                 wrap;
`ifdef CNT_STICKY_EN
    logic                 clr_sticky;
    logic                 sticky;
`endif

    modport master (
        output enable, up, load, load_val, limit, step, sat_mode,
`ifdef CNT_STICKY_EN
        output clr_sticky,
        input  sticky,
`endif
        input  q, tc, wrap
    );

    modport slave (
        input  enable, up, load, load_val, limit, step, sat_mode,
`ifdef CNT_STICKY_EN
        input  clr_sticky,
        output sticky,
`endif
        output q, tc, wrap
    );
endinterface

`default_nettype wire

// File: rtl/counter_up_down_mod.sv
// ============================================================================
// Module      : counter_up_down_mod
// Description : Up/down counter over 0..limit with programmable step, wrap or
//               saturate at the bounds, parallel load, tc and wrap flags.
//               Define CNT_STICKY_EN to add a sticky wrap flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module counter_up_down_mod #(
    parameter int BITS      = 8,
    parameter int STEP_BITS = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    counter_up_down_mod_if.slave   cif
);
    // One bit of headroom over both operands so sums never overflow.
    localparam int c_W = ((BITS + 1) > (STEP_BITS + 1)) ? (BITS + 1) : (STEP_BITS + 1);

    logic [BITS-1:0] r_q;
    logic            r_wrap;
    logic [BITS-1:0] w_q_nxt;
    logic            w_wrap_nxt;

    logic [c_W-1:0]  w_q_x;
    logic [c_W-1:0]  w_lim_x;
    logic [c_W-1:0]  w_lim1;
    logic [c_W-1:0]  w_step_x;
    logic [c_W-1:0]  w_step_eff;
    logic [c_W-1:0]  w_sum;

    assign w_q_x      = c_W'(r_q);
    assign w_lim_x    = c_W'(cif.limit);
    assign w_lim1     = w_lim_x + c_W'(1);
    assign w_step_x   = c_W'(cif.step);
    assign w_step_eff = (w_step_x < w_lim1) ? w_step_x : w_lim1;
    assign w_sum      = w_q_x + w_step_eff;

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (cif.load) begin
            w_q_nxt = (cif.load_val > cif.limit) ? cif.limit : cif.load_val;
        end else if (cif.enable && (cif.step != '0)) begin
            if (w_q_x > w_lim_x) begin
                // Limit was lowered beneath q: re-enter the range at a bound.
                w_wrap_nxt = 1'b1;
                w_q_nxt    = (cif.up && !cif.sat_mode) ? '0 : cif.limit;
            end else if (cif.up) begin
                if (w_sum <= w_lim_x) begin
                    w_q_nxt = BITS'(w_sum);
                end else begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = cif.sat_mode ? cif.limit : BITS'(w_sum - w_lim1);
                end
            end else begin
                if (w_q_x >= w_step_eff) begin
                    w_q_nxt = BITS'(w_q_x - w_step_eff);
                end else begin
                    w_wrap_nxt = 1'b1;
                    w_q_nxt    = cif.sat_mode ? '0 : BITS'(w_q_x + w_lim1 - w_step_eff);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign cif.q    = r_q;
    assign cif.wrap = r_wrap;
    assign cif.tc   = (cif.up && (r_q == cif.limit)) || (!cif.up && (r_q == '0));

`ifdef CNT_STICKY_EN
    logic r_sticky;

    // A wrap in the same cycle beats the clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (w_wrap_nxt) begin
            r_sticky <= 1'b1;
        end else if (cif.clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign cif.sticky = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_up_down_mod.sv
// ============================================================================
// Module      : tb_counter_up_down_mod
// Description : Directed self-checking bench for counter_up_down_mod
//               (sticky checks only when CNT_STICKY_EN is defined).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_counter_up_down_mod;
    localparam int BITS      = 8;
    localparam int STEP_BITS = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    counter_up_down_mod_if #(.BITS(BITS), .STEP_BITS(STEP_BITS)) cif ();

    counter_up_down_mod #(.BITS(BITS), .STEP_BITS(STEP_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_qw(input string tag, input int eq, input int ew);
        check({tag, ".q"}, 32'(cif.q), 32'(eq));
        check({tag, ".wrap"}, 32'(cif.wrap), 32'(ew));
    endtask

    task automatic do_load(input int v);
        cif.load     = 1'b1;
        cif.enable   = 1'b0;
        cif.load_val = BITS'(v);
        tick();
        cif.load     = 1'b0;
    endtask

    initial begin
        int exp2_q [4] = '{8, 4, 0, 6};
        int exp2_w [4] = '{1, 0, 0, 1};
        tests = 0;
        fails = 0;
        reset        = 1'b1;
        cif.enable   = 1'b0;
        cif.up       = 1'b0;
        cif.load     = 1'b0;
        cif.load_val = '0;
        cif.limit    = 8'd9;
        cif.step     = 4'd1;
        cif.sat_mode = 1'b0;
`ifdef CNT_STICKY_EN
        cif.clr_sticky = 1'b0;
`endif
        tick();
        tick();
        check_qw("reset", 0, 0);
        check("reset.tc_down", 32'(cif.tc), 32'd1);
        cif.up = 1'b1;
        #1;
        check("reset.tc_up", 32'(cif.tc), 32'd0);

        // 1: modulo-10 up counting
        reset      = 1'b0;
        cif.enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_qw($sformatf("t1.%0d", i), i % 10, (i == 10) ? 1 : 0);
            check($sformatf("t1.%0d.tc", i), 32'(cif.tc), ((i % 10) == 9) ? 32'd1 : 32'd0);
        end

        // 2: down by 4 with wrap, limit 9
        do_load(2);
        check_qw("t2.load", 2, 0);
        cif.enable = 1'b1;
        cif.up     = 1'b0;
        cif.step   = 4'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_qw($sformatf("t2.%0d", i), exp2_q[i], exp2_w[i]);
        end

        // 3: saturate at 200 with step 15, then count down
        cif.limit    = 8'd200;
        cif.sat_mode = 1'b1;
        cif.step     = 4'd15;
        do_load(190);
        check_qw("t3.load", 190, 0);
        cif.enable = 1'b1;
        cif.up     = 1'b1;
        tick();
        check_qw("t3.up1", 200, 1);
        check("t3.tc", 32'(cif.tc), 32'd1);
        tick();
        check_qw("t3.up2", 200, 1);
        cif.up = 1'b0;
        tick();
        check_qw("t3.dn1", 185, 0);
        tick();
        check_qw("t3.dn2", 170, 0);

        // 4: load clamps and beats enable; lowered limit wraps on next count
        cif.limit = 8'd100;
        do_load(50);
        check_qw("t4.load50", 50, 0);
        cif.load     = 1'b1;
        cif.enable   = 1'b1;
        cif.load_val = 8'd250;
        cif.up       = 1'b1;
        tick();
        check_qw("t4.clamp", 100, 0);
        cif.load     = 1'b0;
        cif.limit    = 8'd30;
        cif.sat_mode = 1'b0;
        tick();
        check_qw("t4.oor_up", 0, 1);
        cif.load     = 1'b1;
        cif.load_val = 8'd5;
        tick();
        check_qw("t4.load_clears_wrap", 5, 0);
        cif.load = 1'b0;

        // 5: reset cancels pending wrap; hold via enable=0 and step=0
        cif.limit = 8'd9;
        cif.up    = 1'b0;
        cif.step  = 4'd8;
        tick();
        check_qw("t5.pre", 7, 1);
        reset = 1'b1;
        tick();
        check_qw("t5.reset", 0, 0);
        reset = 1'b0;
        do_load(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_qw($sformatf("t5.hold_en.%0d", i), 3, 0);
        end
        cif.enable = 1'b1;
        cif.step   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_qw($sformatf("t5.hold_step.%0d", i), 3, 0);
        end
        cif.step = 4'd8;
        tick();
        check_qw("t5.wrap_dn", 5, 1);
        cif.enable = 1'b0;
        tick();
        check_qw("t5.hold_clears_wrap", 5, 0);

        // limit=0 pins q at 0 and every enabled count flags wrap
        cif.limit  = 8'd0;
        cif.enable = 1'b1;
        cif.up     = 1'b1;
        cif.step   = 4'd3;
        tick();
        check_qw("l0.oor", 0, 1);
        tick();
        check_qw("l0.up", 0, 1);
        cif.up = 1'b0;
        tick();
        check_qw("l0.dn", 0, 1);

        // out-of-range down goes to limit; sat-mode up clips to limit
        cif.limit = 8'd9;
        cif.step  = 4'd1;
        do_load(9);
        cif.limit  = 8'd4;
        cif.enable = 1'b1;
        tick();
        check_qw("oor.dn", 4, 1);
        cif.limit = 8'd9;
        do_load(9);
        cif.limit    = 8'd4;
        cif.sat_mode = 1'b1;
        cif.up       = 1'b1;
        cif.enable   = 1'b1;
        tick();
        check_qw("oor.up_sat", 4, 1);

        // full range: plain modulo-256
        cif.sat_mode = 1'b0;
        cif.limit    = 8'd255;
        do_load(254);
        cif.enable = 1'b1;
        tick();
        check_qw("full.255", 255, 0);
        tick();
        check_qw("full.0", 0, 1);

`ifdef CNT_STICKY_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sticky.reset", 32'(cif.sticky), 32'd0);
        cif.limit = 8'd9;
        do_load(9);
        cif.enable = 1'b1;
        tick();
        check("sticky.set", 32'(cif.sticky), 32'd1);
        cif.enable = 1'b0;
        tick();
        check("sticky.hold", 32'(cif.sticky), 32'd1);
        cif.clr_sticky = 1'b1;
        tick();
        check("sticky.clr", 32'(cif.sticky), 32'd0);
        cif.clr_sticky = 1'b0;
        do_load(9);
        cif.clr_sticky = 1'b1;
        cif.enable     = 1'b1;
        tick();
        check("sticky.set_beats_clr", 32'(cif.sticky), 32'd1);
        cif.clr_sticky = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
